// File: rtl/sw_mode_press.sv
// -----------------------------------------------------------------------------
// sw_mode_press
//
// Turns the raw mode push-button into a clean debounced level, a single-cycle
// press strobe (SW_MODE) for the mode-select block, and a single-cycle
// long-press strobe (SW_LONG). Everything runs in the CLK domain. SW_RAW is
// asynchronous to CLK, so it first passes through a two-flop synchronizer.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   SW_RAW   in   raw button (1 = pressed), asynchronous to CLK
//   SW_LEVEL out  debounced button level
//   SW_MODE  out  one-cycle press strobe
//   SW_LONG  out  one-cycle long-press strobe
//
// Optional feature: when the macro SW_MODE_PRESS_AUTOREPEAT_EN is defined,
// the state reached after a long press auto-repeats SW_MODE every
// REPEAT_CYCLES cycles until the button is released.
// -----------------------------------------------------------------------------
module sw_mode_press #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_RAW,
    output logic SW_LEVEL,
    output logic SW_MODE,
    output logic SW_LONG
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
        $error("sw_mode_press: cycle parameters must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 31 ||
        DEBOUNCE_CYCLES >= (1 << CNT_W) || LONG_CYCLES >= (1 << CNT_W) ||
        REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_width
        $error("sw_mode_press: CNT_W too small for the configured counts");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
`ifdef SW_MODE_PRESS_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

`ifdef SW_MODE_PRESS_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
`endif

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             level_q, level_d;
    logic             rise, fall;
    logic [CNT_W-1:0] hcnt_q;
    state_t           state_q;
    logic             mode_q, long_q;
`ifdef SW_MODE_PRESS_AUTOREPEAT_EN
    logic [CNT_W-1:0] rcnt_q;
`endif

    // Two-flop synchronizer; only sync2_q is used downstream.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= SW_RAW;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level follows sync2 only after DEBOUNCE_CYCLES
    // consecutive samples disagreeing with it; any agreeing sample restarts
    // the count, so short bounces never reach the output.
    always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q;
        if (sync2_q == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            level_d = sync2_q;
            dcnt_d  = '0;
        end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
        end
    end

    // The FSM reacts on the same edge the debounced level changes, so the
    // press strobe coincides with the SW_LEVEL rising edge.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt_q  <= '0;
            level_q <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
        end
    end

    // Press FSM with registered strobes. Release is checked first in every
    // state so that a release coinciding with the long threshold (or a
    // repeat edge) suppresses that strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            mode_q  <= 1'b0;
            long_q  <= 1'b0;
`ifdef SW_MODE_PRESS_AUTOREPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            mode_q <= 1'b0;
            long_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        mode_q  <= 1'b1;
                        hcnt_q  <= '0;
                        state_q <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        hcnt_q  <= '0;
                        state_q <= IDLE;
                    end else if (hcnt_q == LONG_LAST) begin
                        // hcnt saturates at LONG_CYCLES from here on.
                        hcnt_q  <= LONG_MAX;
                        long_q  <= 1'b1;
`ifdef SW_MODE_PRESS_AUTOREPEAT_EN
                        rcnt_q  <= '0;
                        state_q <= REPEAT;
`else
                        state_q <= HELD;
`endif
                    end else begin
                        hcnt_q <= hcnt_q + CNT_W'(1);
                    end
                end
`ifdef SW_MODE_PRESS_AUTOREPEAT_EN
                REPEAT: begin
                    if (fall) begin
                        hcnt_q  <= '0;
                        rcnt_q  <= '0;
                        state_q <= IDLE;
                    end else if (rcnt_q == REP_LAST) begin
                        mode_q <= 1'b1;
                        rcnt_q <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + CNT_W'(1);
                    end
                end
`else
                HELD: begin
                    if (fall) begin
                        hcnt_q  <= '0;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    hcnt_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SW_LEVEL = level_q;
    assign SW_MODE  = mode_q;
    assign SW_LONG  = long_q;

endmodule
